// File: rtl/incrementador.sv
// Push-button up-counter: 2-flop synchronizer, 4-state debounce FSM giving one
// increment per accepted press, synchronous load, and wrap or saturate at max.
module incrementador #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 4,
  parameter int SATURATE   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_add,
  input  logic         load,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         ovf,
  output logic         at_max
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  MAX      = '1;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic          s1_q, btn_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inc;
  logic [N-1:0]  val_q, val_d;
  logic          ovf_q, ovf_d;

  // inc is decoded combinationally so the count moves on the same edge the
  // FSM enters HELD, i.e. DEB_CYCLES edges after btn_s first reads high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = HELD;
            inc     = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_CHK: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          inc     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = REL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      REL_CHK: begin
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load beats a coincident increment; the FSM still moves to HELD regardless.
  always_comb begin
    val_d = val_q;
    ovf_d = 1'b0;
    if (load) begin
      val_d = data_in;
    end else if (inc) begin
      if (val_q != MAX) begin
        val_d = val_q + N'(1);
      end else begin
        ovf_d = 1'b1;
        val_d = (SATURATE != 0) ? MAX : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= btn_add;
      btn_s_q <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = val_q;
  assign ovf      = ovf_q;
  assign at_max   = (val_q == MAX);

endmodule

// File: tb/tb_incrementador.sv
// Directed bench for incrementador: wrap, saturate and 2-bit instances share
// stimulus; expectations are queued as stimulus is applied and checked later.
module tb_incrementador;

  logic       clk = 1'b0;
  logic       rst, btn, load;
  logic [3:0] din;
  logic [1:0] din_c;
  logic [3:0] qa, qb;
  logic [1:0] qc;
  logic       ova, ovb, ovc, mxa, mxb, mxc;

  always #5 clk = ~clk;

  incrementador #(.N(4), .DEB_CYCLES(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .btn_add(btn), .load(load), .data_in(din),
    .data_out(qa), .ovf(ova), .at_max(mxa));
  incrementador #(.N(4), .DEB_CYCLES(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .btn_add(btn), .load(load), .data_in(din),
    .data_out(qb), .ovf(ovb), .at_max(mxb));
  incrementador #(.N(2), .DEB_CYCLES(4), .SATURATE(0)) u_n2 (
    .clk(clk), .rst(rst), .btn_add(btn), .load(load), .data_in(din_c),
    .data_out(qc), .ovf(ovc), .at_max(mxc));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    dut;
    int    val;
    int    ovf;
    int    amax;
  } exp_t;

  exp_t exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int dut, input int val,
                            input int o, input int m);
    exp_t e;
    e.tag = tag; e.dut = dut; e.val = val; e.ovf = o; e.amax = m;
    exp_q.push_back(e);
  endtask

  task automatic check_outs();
    exp_t   e;
    integer av, ao, am;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin av = qa; ao = ova; am = mxa; end
        1:       begin av = qb; ao = ovb; am = mxb; end
        default: begin av = qc; ao = ovc; am = mxc; end
      endcase
      checks++;
      assert (av === e.val) else begin
        failures++;
        $error("FAIL %s dut%0d data_out observed=%0d expected=%0d", e.tag, e.dut, av, e.val);
      end
      checks++;
      assert (ao === e.ovf) else begin
        failures++;
        $error("FAIL %s dut%0d ovf observed=%0d expected=%0d", e.tag, e.dut, ao, e.ovf);
      end
      checks++;
      assert (am === e.amax) else begin
        failures++;
        $error("FAIL %s dut%0d at_max observed=%0d expected=%0d", e.tag, e.dut, am, e.amax);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; btn = 1'b0; load = 1'b0; din = '0; din_c = '0;
    tick(2);
    expect_out("rst_init", 0, 0, 0, 0);
    expect_out("rst_init", 1, 0, 0, 0);
    expect_out("rst_init", 2, 0, 0, 0);
    check_outs();
    rst = 1'b1;
    tick(2);

    load = 1'b1; din = 4'd13; din_c = 2'd1;
    tick(1);
    load = 1'b0;
    expect_out("load13", 0, 13, 0, 0);
    expect_out("load13", 1, 13, 0, 0);
    expect_out("load1", 2, 1, 0, 0);
    check_outs();

    btn = 1'b1;
    tick(5);
    expect_out("press1_early", 0, 13, 0, 0);
    check_outs();
    tick(1);
    expect_out("press1", 0, 14, 0, 0);
    expect_out("press1", 1, 14, 0, 0);
    expect_out("press1", 2, 2, 0, 0);
    check_outs();
    tick(14);
    expect_out("hold_norepeat", 0, 14, 0, 0);
    check_outs();
    btn = 1'b0;
    tick(10);

    btn = 1'b1;
    tick(6);
    expect_out("press2", 0, 15, 0, 1);
    expect_out("press2", 1, 15, 0, 1);
    expect_out("press2", 2, 3, 0, 1);
    check_outs();
    tick(14);
    btn = 1'b0;
    tick(10);

    btn = 1'b1;
    tick(6);
    expect_out("wrap", 0, 0, 1, 0);
    expect_out("saturate", 1, 15, 1, 1);
    expect_out("wrap_n2", 2, 0, 1, 0);
    check_outs();
    tick(1);
    expect_out("wrap_ovf_end", 0, 0, 0, 0);
    expect_out("sat_ovf_end", 1, 15, 0, 1);
    expect_out("n2_ovf_end", 2, 0, 0, 0);
    check_outs();
    tick(13);
    btn = 1'b0;
    tick(10);

    load = 1'b1; din = 4'd5;
    tick(1);
    load = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1;
      tick(w);
      btn = 1'b0;
      tick(3);
    end
    tick(6);
    expect_out("bounce_short", 0, 5, 0, 0);
    check_outs();
    for (int r = 0; r < 4; r++) begin
      btn = 1'b1;
      tick(6);
      btn = 1'b0;
      tick(2);
    end
    btn = 1'b1;
    tick(6);
    btn = 1'b0;
    tick(10);
    expect_out("dropout", 0, 6, 0, 0);
    check_outs();

    btn = 1'b1;
    tick(5);
    load = 1'b1; din = 4'd2;
    tick(1);
    load = 1'b0;
    expect_out("collide", 0, 2, 0, 0);
    check_outs();
    tick(10);
    expect_out("collide_hold", 0, 2, 0, 0);
    check_outs();
    btn = 1'b0;
    tick(10);
    btn = 1'b1;
    tick(6);
    expect_out("after_collide", 0, 3, 0, 0);
    check_outs();
    tick(6);
    btn = 1'b0;
    tick(10);

    load = 1'b1; din = 4'd9;
    tick(1);
    load = 1'b0;
    expect_out("preload9", 0, 9, 0, 0);
    check_outs();
    btn = 1'b1;
    tick(3);
    rst = 1'b0;
    #2;
    expect_out("rst_async", 0, 0, 0, 0);
    expect_out("rst_async", 1, 0, 0, 0);
    check_outs();
    tick(3);
    rst = 1'b1;
    tick(5);
    expect_out("requal_early", 0, 0, 0, 0);
    check_outs();
    tick(1);
    expect_out("requal", 0, 1, 0, 0);
    check_outs();
    btn = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/incrementador.md
# incrementador

Parametrized N-bit up-counter driven by a raw push-button. It is the counting-up counterpart of the lab's button-driven subtractor. The raw button is synchronized, debounced by an explicit FSM, and reduced to exactly one increment per accepted press. The block also provides a synchronous parallel load, a selectable wrap/saturate policy, and overflow/at-max status for display or LED logic on the FPGA board.

## Interface
- N, default 4: counter width in bits; legal range ≥ 1.
- DEB_CYCLES, default 4: consecutive identical synchronized samples required to accept a press or a release; legal range ≥ 1.
- SATURATE, default 0: overflow policy. 0 = wrap max→0; 1 = hold at max.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous assertion, active-low.
- btn_add  in  1  raw button level, asynchronous to clk, may bounce; 1 = pressed.
- load  in  1  synchronous load strobe, high for one or more cycles.
- data_in  in  N  load value.
- data_out  out  N  counter value.
- ovf  out  1  one-cycle pulse when an accepted press occurs while data_out = 2^N−1.
- at_max  out  1  level; 1 whenever data_out = 2^N−1.

## Operation
- Synchronizer: 2-flop chain btn_add → s1 → btn_s, both flops reset to 0.
- Debounce FSM, 4 states, with cnt counting from 0 to DEB_CYCLES−1:
  - IDLE: if btn_s=1, go to PRESS_CHK with cnt=1. Otherwise stay.
  - PRESS_CHK: if btn_s=0, go to IDLE. If btn_s=1 and cnt=DEB_CYCLES−1, go to HELD and assert the internal inc for exactly this cycle. Otherwise cnt++.
  - HELD: if btn_s=0, go to REL_CHK with cnt=1. Otherwise stay. A held button never auto-repeats.
  - REL_CHK: if btn_s=1, go back to HELD with no inc. If btn_s=0 and cnt=DEB_CYCLES−1, go to IDLE. Otherwise cnt++.
  - DEB_CYCLES=1 special case: IDLE goes directly to HELD with inc asserted; HELD goes directly to IDLE.
- Counter update, in priority order per clock edge:
  1. load=1: data_out ← data_in, ovf ← 0. A coincident inc is discarded, but the FSM still advances to HELD.
  2. inc=1 and data_out < max: data_out ← data_out+1, ovf ← 0.
  3. inc=1 and data_out = max: ovf ← 1. data_out ← 0 if SATURATE=0, otherwise it stays at max.
  4. Otherwise: data_out holds, ovf ← 0.
- Arithmetic is unsigned, modulo 2^N. No carry is exposed beyond ovf.
- at_max is combinational from data_out.

## Timing
- Reset (rst=0), applied asynchronously and immediately: data_out=0, ovf=0, at_max=0 (at_max=1 only if N would make max=0, which is impossible for N≥1). s1, btn_s and cnt are 0; FSM is in IDLE.
- Reset mid-operation aborts any partial debounce. If the button is still held after rst rises, it is treated as a new press and re-qualified in full.
- rst deassertion is sampled normally; the first counter activity is possible no earlier than the 2nd edge after release.
- Press latency:
  - Let btn_add be high and stable before rising edge k.
  - btn_s becomes 1 after edge k+1.
  - data_out changes at edge k+1+DEB_CYCLES (k+5 at the default).
  - ovf is high for the single cycle following that edge.
- Release qualification takes DEB_CYCLES synchronized samples. A new press is accepted only after the FSM has returned to IDLE.
- Glitch rejection:
  - Any high pulse with fewer than DEB_CYCLES consecutive btn_s=1 samples produces no increment.
  - Any low dropout during HELD shorter than DEB_CYCLES samples produces no additional increment.
- load takes effect at the next rising edge, with 1-cycle latency, and is independent of the FSM state.

## Test plan
- Reset: N=4, data_out preloaded to 9, then drive rst=0 between clock edges → data_out=0, ovf=0, at_max=0 immediately, without waiting for a clock edge.
- Load and single press (N=4, DEB_CYCLES=4): load data_in=13 → data_out=13. Hold btn_add high for 20 cycles → data_out=14 at edge k+5, then stays 14 for the rest of the hold. Release 10 cycles, press again → data_out=15, at_max=1.
- Wrap vs saturate: SATURATE=0 from 15, one press → data_out=0, ovf=1 for one cycle, at_max=0. SATURATE=1 from 15 → data_out stays 15, ovf=1 for one cycle. N=2 instance from 3 with SATURATE=0 → data_out=0.
- Bounce rejection: starting from data_out=5, apply btn_add high pulses of 1, 2 and 3 cycles separated by 3 low cycles → data_out stays 5. Then hold the button with 2-cycle low dropouts every 8 cycles → exactly one increment, data_out=6.
- Load collision: drive load=1 with data_in=2 in the same cycle the press qualifies → data_out=2, ovf=0. A subsequent clean press → data_out=3.
- Reset mid-press: assert rst for 3 cycles while the FSM is in PRESS_CHK and the button stays held → data_out=0. After release of rst, the still-held button yields data_out=1 at edge (rst-release edge)+1+DEB_CYCLES.
